arm_membus_bridge: RTL and testbench
====================================

# arm_membus_bridge

Parametrised memory-bus bridge for the multicycle ARM core: replaces the fixed single-cycle memory assumption with a valid/ready request channel and a separate read-response channel. It captures a core access, drives it onto the bus, and holds the core in a stall until the access completes. It sits between the core's `Adr`/`WriteData`/`MemWrite`/`ReadData` path and the memory or interconnect.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, maximum cycles spent in REQ+WAIT_RSP before abort; only used with the watchdog compiled in. Legal range is 1 or more.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `core_req`  in  1  core requests an access; held high while `core_stall` is high.
- `core_we`  in  1  1 = write, 0 = read.
- `core_adr`  in  ADDR_W  access address.
- `core_wdata`  in  DATA_W  write data.
- `core_rdata`  out  DATA_W  registered read data; valid in the DONE cycle, then held.
- `core_stall`  out  1  core must freeze its state.
- `bus_err`  out  1  one-cycle pulse in DONE when the access was aborted.
- `m_valid`  out  1  request valid.
- `m_ready`  in  1  request accepted.
- `m_we`, `m_adr`, `m_wdata`  out  1/ADDR_W/DATA_W  latched request fields.
- `r_valid`  in  1  read response valid.
- `r_data`  in  DATA_W  read response data.

## Operation
- States are IDLE, REQ, WAIT_RSP and DONE.
- **IDLE:**
  - When `core_req`=1, latch `core_we`, `core_adr` and `core_wdata`, then go to REQ.
- **REQ:**
  - `m_valid`=1 with the latched fields, which stay stable until `m_ready`.
  - On `m_ready`: a write goes to DONE (writes are posted, no response expected).
  - On `m_ready` for a read: if `r_valid` is also high in the same cycle, capture `r_data` and go to DONE; otherwise go to WAIT_RSP.
- **WAIT_RSP:**
  - On `r_valid`, capture `r_data` into `core_rdata` and go to DONE.
- **DONE:**
  - Lasts one cycle. `core_stall`=0, then go to IDLE.
- `core_stall` is combinational: `core_req` AND (state != DONE). The core is frozen from the cycle it raises `core_req`.
- `r_valid` is ignored in IDLE, in DONE, and in REQ before `m_ready`.
- `core_rdata` updates only on a captured read or a timeout abort. Writes leave it unchanged.
- Reset values:
  - State is IDLE.
  - `core_rdata`, `m_adr` and `m_wdata` are 0.
  - `m_we`, `m_valid` and `bus_err` are 0.
- Reset mid-access:
  - The bridge returns to IDLE at the next edge and `m_valid` drops.
  - Any late `r_valid` for that access is ignored.
- Back-to-back accesses: if `core_req` is still or again high in the IDLE cycle after DONE, a new access starts. There is no idle bubble beyond that IDLE cycle.

## Timing
- Minimum read (`m_ready` and `r_valid` both high in the first REQ cycle):
  - `core_req` in cycle 0, REQ in cycle 1, DONE in cycle 2.
  - The core is stalled in cycles 0–1 and released in cycle 2.
- Minimum write: same three-cycle profile.
- Each cycle of `m_ready` low adds one cycle; each cycle waiting for `r_valid` adds one cycle.
- `m_*` outputs are registered. `core_stall` is the only combinational output.

## Configuration
- `ARM_MEMBUS_WDOG_EN` defined:
  - A counter runs while in REQ or WAIT_RSP. It clears on entry to REQ and is sized `$clog2(TIMEOUT+1)` bits.
  - When the count reaches TIMEOUT, the bridge goes to DONE, drops `m_valid`, sets `core_rdata` to all ones and pulses `bus_err`.
  - If `m_ready` or `r_valid` arrives in the same cycle the count reaches TIMEOUT, normal completion wins and there is no error.
- `ARM_MEMBUS_WDOG_EN` not defined:
  - The bridge waits indefinitely.
  - `bus_err` is tied to 0 and there is no counter logic.

## Structure
- Package `arm_membus_pkg` holds:
  - The state enum (IDLE, REQ, WAIT_RSP, DONE).
  - The error-data constant (all ones, sized by DATA_W at the use site).
- Sub-module `arm_membus_wdog` contains the timeout counter. Ports: `clk`, `reset`, `run`, `clr`, `expired`. It is instantiated only under the macro.

## Test plan
- Read with zero-latency memory: `core_req`=1, `core_we`=0, `core_adr`=0x100, with `m_ready` and `r_valid` high in REQ and `r_data`=0xCAFEF00D → stall in cycles 0–1, DONE in cycle 2 with `core_rdata`=0xCAFEF00D.
- Write with `m_ready` delayed 3 cycles: `core_adr`=0x40, `core_wdata`=0x12345678 → `m_valid` held with stable fields for 4 cycles, then DONE; no response is awaited and `core_rdata` is unchanged.
- Read with `r_valid` arriving 5 cycles after `m_ready` → WAIT_RSP for 5 cycles, then data captured. A spurious `r_valid` in IDLE beforehand is ignored.
- Reset (`reset`=0) asserted during WAIT_RSP → IDLE at the next edge with all outputs at reset values. A late `r_valid`=1 with 0xFFFF0000 leaves `core_rdata`=0.
- Watchdog (macro on, TIMEOUT=4, `m_ready` held low) → abort after 4 cycles in REQ, `bus_err`=1 for one cycle, `core_rdata`=0xFFFFFFFF. With the macro off, the bridge stalls indefinitely.
- Back-to-back: a read followed immediately by a write with `core_req` held → the two accesses are separated by exactly one IDLE cycle.

Source files
------------

// File: rtl/arm_membus_pkg.sv
// arm_membus_pkg: shared types and constants for the ARM memory-bus bridge.
//   state_e     - bridge FSM states
//   ErrFillBit  - fill bit for read data returned by an aborted access
//                 (replicate to DATA_W at the use site)
package arm_membus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRsp,
    StDone
  } state_e;

  localparam logic ErrFillBit = 1'b1;

endpackage

// File: rtl/arm_membus_wdog.sv
// arm_membus_wdog: access timeout counter for the memory-bus bridge.
// Only instantiated when ARM_MEMBUS_WDOG_EN is defined.
// Ports:
//   clk     in  rising-edge clock
//   reset   in  synchronous active-low reset
//   run     in  count one cycle spent in the access
//   clr     in  restart the count (access entering REQ)
//   expired out this running cycle is cycle TIMEOUT of the access
module arm_membus_wdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CntW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_cnt_inc;
    end
  end

  // r_cnt holds the cycles already spent, so the count reaches TIMEOUT in this cycle.
  assign expired = run && (w_cnt_inc == CntW'(TIMEOUT));

endmodule

// File: rtl/arm_membus_bridge.sv
// arm_membus_bridge: turns the multicycle core's single-cycle memory access into a
// valid/ready request plus a separate read-response channel, stalling the core until
// the access completes.
// Optional feature: define ARM_MEMBUS_WDOG_EN to abort accesses that spend TIMEOUT
// cycles in REQ+WAIT_RSP (read data all ones, one-cycle bus_err pulse).
// Ports:
//   clk, reset                        clock, synchronous active-low reset
//   core_req/we/adr/wdata   in        core access request
//   core_rdata              out       registered read data, valid in DONE then held
//   core_stall              out       combinational core freeze
//   bus_err                 out       abort pulse in DONE (0 without watchdog)
//   m_valid/we/adr/wdata    out       registered bus request
//   m_ready                 in        bus request accepted
//   r_valid, r_data         in        read response channel
module arm_membus_bridge
  import arm_membus_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  output logic              bus_err,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              r_valid,
  input  logic [DATA_W-1:0] r_data
);

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("arm_membus_bridge: TIMEOUT must be at least 1");
  end

  state_e            r_state, w_state_d;
  logic              w_latch, w_capture, w_abort, w_expired;
  logic              r_m_valid, r_m_we;
  logic [ADDR_W-1:0] r_m_adr;
  logic [DATA_W-1:0] r_m_wdata, r_core_rdata;

  always_comb begin
    w_state_d = r_state;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (core_req) begin
          w_latch   = 1'b1;
          w_state_d = StReq;
        end
      end
      StReq: begin
        // Completion takes priority over an expiry in the same cycle.
        if (m_ready) begin
          if (r_m_we) begin
            w_state_d = StDone;
          end else if (r_valid) begin
            w_capture = 1'b1;
            w_state_d = StDone;
          end else begin
            w_state_d = StWaitRsp;
          end
        end else if (w_expired) begin
          w_abort   = 1'b1;
          w_state_d = StDone;
        end
      end
      StWaitRsp: begin
        if (r_valid) begin
          w_capture = 1'b1;
          w_state_d = StDone;
        end else if (w_expired) begin
          w_abort   = 1'b1;
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_m_valid    <= 1'b0;
      r_m_we       <= 1'b0;
      r_m_adr      <= '0;
      r_m_wdata    <= '0;
      r_core_rdata <= '0;
    end else begin
      r_state   <= w_state_d;
      r_m_valid <= (w_state_d == StReq);
      if (w_latch) begin
        r_m_we    <= core_we;
        r_m_adr   <= core_adr;
        r_m_wdata <= core_wdata;
      end
      if (w_capture) begin
        r_core_rdata <= r_data;
      end else if (w_abort) begin
        r_core_rdata <= {DATA_W{ErrFillBit}};
      end
    end
  end

`ifdef ARM_MEMBUS_WDOG_EN
  logic w_wdog_run;
  logic r_bus_err;

  assign w_wdog_run = (r_state == StReq) || (r_state == StWaitRsp);

  arm_membus_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .run     (w_wdog_run),
    .clr     (w_latch),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_abort;
    end
  end

  assign bus_err = r_bus_err;
`else
  assign w_expired = 1'b0;
  assign bus_err   = 1'b0;
`endif

  assign core_stall = core_req && (r_state != StDone);
  assign core_rdata = r_core_rdata;
  assign m_valid    = r_m_valid;
  assign m_we       = r_m_we;
  assign m_adr      = r_m_adr;
  assign m_wdata    = r_m_wdata;

endmodule

// File: tb/tb_arm_membus_bridge.sv
// tb_arm_membus_bridge: self-checking bench for arm_membus_bridge. Each access is
// predicted as a timeline (request cycles, response wait, DONE cycle) computed from
// the chosen bus delays; junk r_valid/m_ready are driven where they must be ignored.
module tb_arm_membus_bridge;

  localparam int unsigned TbTimeout = 4;
`ifdef ARM_MEMBUS_WDOG_EN
  localparam bit WdogOn = 1'b1;
`else
  localparam bit WdogOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [31:0] core_adr, core_wdata, core_rdata;
  logic        core_stall, bus_err;
  logic        m_valid, m_ready, m_we;
  logic [31:0] m_adr, m_wdata;
  logic        r_valid;
  logic [31:0] r_data;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_rdata;

  always #5 clk = ~clk;

  arm_membus_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TbTimeout)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_adr   (core_adr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_stall (core_stall),
    .bus_err    (bus_err),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_we       (m_we),
    .m_adr      (m_adr),
    .m_wdata    (m_wdata),
    .r_valid    (r_valid),
    .r_data     (r_data)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access starting in an IDLE cycle (k=0). Read response arrives rsp_dly cycles
  // after the m_ready cycle (0 = same cycle).
  task automatic do_access(input bit we, input logic [31:0] adr, input logic [31:0] wdata,
                           input logic [31:0] rsp, input int ready_dly, input int rsp_dly);
    int natural_done;
    int done_k;
    bit abort;
    natural_done = 2 + ready_dly + (we ? 0 : rsp_dly);
    done_k       = natural_done;
    abort        = 1'b0;
    if (WdogOn && natural_done > int'(TbTimeout) + 1) begin
      done_k = int'(TbTimeout) + 1;
      abort  = 1'b1;
    end
    for (int k = 0; k <= done_k; k++) begin
      @(posedge clk);
      #1;
      m_ready = 1'b0;
      r_valid = 1'(($urandom_range(0, 1)));
      r_data  = $urandom;
      if (k == 0) begin
        core_req   = 1'b1;
        core_we    = we;
        core_adr   = adr;
        core_wdata = wdata;
        m_ready    = 1'(($urandom_range(0, 1)));
      end else if (k == done_k) begin
        m_ready = 1'(($urandom_range(0, 1)));
      end else if (k <= 1 + ready_dly) begin
        if (k == 1 + ready_dly) begin
          m_ready = 1'b1;
          if (!we) begin
            r_valid = (rsp_dly == 0);
            r_data  = rsp;
          end
        end
      end else begin
        r_valid = (k == 1 + ready_dly + rsp_dly);
        r_data  = rsp;
      end
      #1;
      if (k == done_k) begin
        if (abort) ref_rdata = 32'hFFFF_FFFF;
        else if (!we) ref_rdata = rsp;
        check_eq("done_stall", core_stall, 1'b0);
        check_eq("done_rdata", core_rdata, ref_rdata);
        check_eq("done_bus_err", bus_err, abort);
        check_eq("done_m_valid", m_valid, 1'b0);
      end else begin
        check_eq("busy_stall", core_stall, 1'b1);
        check_eq("busy_bus_err", bus_err, 1'b0);
        check_eq("busy_rdata_held", core_rdata, ref_rdata);
        if (k == 0) begin
          check_eq("idle_m_valid", m_valid, 1'b0);
        end else if (k <= 1 + ready_dly) begin
          check_eq("req_m_valid", m_valid, 1'b1);
          check_eq("req_m_we", m_we, we);
          check_eq("req_m_adr", m_adr, adr);
          check_eq("req_m_wdata", m_wdata, wdata);
        end else begin
          check_eq("wait_m_valid", m_valid, 1'b0);
        end
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      core_req = 1'b0;
      m_ready  = 1'(($urandom_range(0, 1)));
      r_valid  = 1'(($urandom_range(0, 1)));
      r_data   = $urandom;
      #1;
      check_eq("gap_stall", core_stall, 1'b0);
      check_eq("gap_m_valid", m_valid, 1'b0);
      check_eq("gap_bus_err", bus_err, 1'b0);
      check_eq("gap_rdata", core_rdata, ref_rdata);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_m_valid"}, m_valid, 1'b0);
    check_eq({tag, "_m_we"}, m_we, 1'b0);
    check_eq({tag, "_m_adr"}, m_adr, 32'h0);
    check_eq({tag, "_m_wdata"}, m_wdata, 32'h0);
    check_eq({tag, "_rdata"}, core_rdata, 32'h0);
    check_eq({tag, "_bus_err"}, bus_err, 1'b0);
  endtask

  // Read abandoned by reset while waiting for its response; the late response is dropped.
  task automatic reset_mid_read();
    @(posedge clk); #1;
    core_req = 1'b1; core_we = 1'b0; core_adr = 32'h200; core_wdata = 32'h0;
    m_ready = 1'b0; r_valid = 1'b0;
    @(posedge clk); #1;
    m_ready = 1'b1; r_valid = 1'b0;
    #1;
    check_eq("rst_req_m_valid", m_valid, 1'b1);
    @(posedge clk); #1;
    m_ready = 1'b0; r_valid = 1'b0; reset = 1'b0; core_req = 1'b0;
    #1;
    check_eq("rst_wait_m_valid", m_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; r_valid = 1'b1; r_data = 32'hFFFF_0000;
    #1;
    ref_rdata = 32'h0;
    check_reset_values("rst_mid");
    check_eq("rst_mid_stall", core_stall, 1'b0);
    @(posedge clk); #1;
    r_valid = 1'b0;
    #1;
    check_eq("rst_late_rsp_rdata", core_rdata, 32'h0);
    check_eq("rst_late_rsp_m_valid", m_valid, 1'b0);
  endtask

  initial begin
    reset = 1'b0; core_req = 1'b0; core_we = 1'b0; core_adr = '0; core_wdata = '0;
    m_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    ref_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("por");
    check_eq("por_stall", core_stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    do_access(1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 0);
    idle_cycles(2);
    do_access(1'b1, 32'h40, 32'h1234_5678, 32'h0, 3, 0);
    idle_cycles(1);
    do_access(1'b0, 32'h80, 32'h0, 32'h5A5A_1234, 0, 5);
    idle_cycles(1);
    // Back-to-back: read then write with core_req held through DONE.
    do_access(1'b0, 32'h104, 32'h0, 32'h0BAD_CAFE, 1, 1);
    do_access(1'b1, 32'h108, 32'hDEAD_BEEF, 32'h0, 0, 0);
    idle_cycles(1);
    // Long m_ready stall: aborts with the watchdog, waits it out without.
    do_access(1'b0, 32'h300, 32'h0, 32'h7777_1111, 40, 0);
    idle_cycles(2);
    reset_mid_read();
    idle_cycles(1);

    for (int t = 0; t < 60; t++) begin
      do_access(1'(($urandom_range(0, 1))), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
